// File: rtl/moonbase_pkg.sv
// Shared definitions for the moonbase external bus: bus bit positions,
// address width and nibble-select encoding.
// Imported by moonbase_bus_bridge and moonbase_nibble_ram.
package moonbase_pkg;

  // Field positions within the CPU's multiplexed 8-bit output bus.
  localparam int BUS_STROBE   = 7;
  localparam int BUS_CODE     = 6;
  localparam int BUS_RAM_WE_N = 5;
  localparam int BUS_DEV_WE_N = 4;

  localparam int ADDR_W = 7;

  // Nibble pointer encoding: high nibble is transferred first.
  localparam logic NIB_HI = 1'b0;
  localparam logic NIB_LO = 1'b1;

  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/moonbase_nibble_ram.sv
// Purpose: 2 x DEPTH x 8 code/data SRAM with nibble-wide CPU access and byte-wide host load.
// Latency: async nibble read; nibble and byte writes land on the clock edge.
// Backpressure: none; a load request takes priority over a bus write in the same clock.
// Ports: rd_* async read (space, address, nibble), wr_* nibble write, ld_* byte write.
// DEPTH must be a power of two; smaller depths alias the 7-bit address modulo DEPTH.
module moonbase_nibble_ram
  import moonbase_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic       clk,
  input  logic       rd_space,
  input  addr_t      rd_addr,
  input  logic       rd_nib,
  output logic [3:0] rd_data,
  input  logic       wr_en,
  input  logic       wr_space,
  input  addr_t      wr_addr,
  input  logic       wr_nib,
  input  logic [3:0] wr_data,
  input  logic       ld_en,
  input  logic       ld_space,
  input  addr_t      ld_addr,
  input  logic [7:0] ld_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]       mem [2][DEPTH];
  logic [7:0]       rd_byte;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] ld_idx;

  assign rd_idx = rd_addr[IDX_W-1:0];
  assign wr_idx = wr_addr[IDX_W-1:0];
  assign ld_idx = ld_addr[IDX_W-1:0];

  assign rd_byte = mem[rd_space][rd_idx];
  assign rd_data = (rd_nib == NIB_LO) ? rd_byte[3:0] : rd_byte[7:4];

  // Contents are deliberately not reset so a preload survives reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_space][ld_idx] <= ld_data;
    end else if (wr_en) begin
      if (wr_nib == NIB_LO) begin
        mem[wr_space][wr_idx][3:0] <= wr_data;
      end else begin
        mem[wr_space][wr_idx][7:4] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/moonbase_bus_bridge.sv
// Purpose: external bus of the moonbase CPU: address latch, nibble-serial SRAM, device regs, host preload.
// Latency: reads are combinational from latched state; writes are visible the clock after the edge.
// Backpressure: none; host load is accepted only while reset is high (load_ready mirrors reset).
// Ports: bus_out/bus_in CPU bus, dev_out/dev_in device registers and pins,
//        load_valid/load_ready/load_addr/load_data host preload port.
module moonbase_bus_bridge
  import moonbase_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int N_DEV = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         bus_out,
  output logic [5:0]         bus_in,
  output logic [4*N_DEV-1:0] dev_out,
  input  logic [2*N_DEV-1:0] dev_in,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [7:0]         load_addr,
  input  logic [7:0]         load_data
);

  localparam int DEV_IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

  addr_t                  r_addr;
  logic                   r_nib;
  logic [N_DEV-1:0][3:0]  dev_q;
  logic [N_DEV-1:0][1:0]  dev_in_v;
  logic [DEV_IDX_W-1:0]   dev_idx;
  logic                   strobe;
  logic                   bus_wr;
  logic                   rd_space;
  logic [3:0]             ram_nib;

  assign strobe = bus_out[BUS_STROBE];
  // CPU writes are blocked while reset is high so only the host loader owns the SRAM then.
  assign bus_wr = !reset && !strobe;

  // During a strobe the upper bus bits carry address, so the space select is forced to data.
  assign rd_space = strobe ? 1'b0 : bus_out[BUS_CODE];

  assign dev_idx  = r_addr[DEV_IDX_W-1:0];
  assign dev_in_v = dev_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
      r_nib  <= NIB_HI;
      dev_q  <= '0;
    end else if (strobe) begin
      r_addr <= bus_out[ADDR_W-1:0];
      r_nib  <= NIB_HI;
    end else begin
      // Device write happens on every nibble clock; the last nibble written persists.
      if (!bus_out[BUS_DEV_WE_N]) begin
        dev_q[dev_idx] <= bus_out[3:0];
      end
      r_nib <= NIB_LO;
    end
  end

  moonbase_nibble_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk      (clk),
    .rd_space (rd_space),
    .rd_addr  (r_addr),
    .rd_nib   (r_nib),
    .rd_data  (ram_nib),
    .wr_en    (bus_wr && !bus_out[BUS_RAM_WE_N]),
    .wr_space (bus_out[BUS_CODE]),
    .wr_addr  (r_addr),
    .wr_nib   (r_nib),
    .wr_data  (bus_out[3:0]),
    .ld_en    (load_valid && reset),
    .ld_space (load_addr[7]),
    .ld_addr  (load_addr[ADDR_W-1:0]),
    .ld_data  (load_data)
  );

  assign bus_in     = {dev_in_v[dev_idx], ram_nib};
  assign dev_out    = dev_q;
  assign load_ready = reset;

endmodule

// File: tb/tb_moonbase_bus_bridge.sv
module tb_moonbase_bus_bridge;

  logic        clk;
  logic        reset;
  logic [7:0]  bus_out;
  logic [5:0]  bus_in;
  logic [15:0] dev_out;
  logic [7:0]  dev_in;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  load_addr;
  logic [7:0]  load_data;

  moonbase_bus_bridge #(.DEPTH(128), .N_DEV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_out    (bus_out),
    .bus_in     (bus_in),
    .dev_out    (dev_out),
    .dev_in     (dev_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_addr  (load_addr),
    .load_data  (load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for one clock, pushed by stimulus, popped by the monitor.
  typedef struct {
    logic        chk_ram;
    logic [3:0]  ram;
    logic [1:0]  dev;
    logic [15:0] dout;
    logic        rdy;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: byte memory, latched address, nibble phase, device regs.
  logic [7:0] m_mem [2][128];
  int         m_addr;
  bit         m_lo;
  logic [3:0] m_dev [4];

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (load_ready !== e.rdy) begin
        failures++;
        $display("FAIL load_ready got=%b exp=%b t=%0t", load_ready, e.rdy, $time);
      end
      checks++;
      if (dev_out !== e.dout) begin
        failures++;
        $display("FAIL dev_out got=%h exp=%h t=%0t", dev_out, e.dout, $time);
      end
      checks++;
      if (bus_in[5:4] !== e.dev) begin
        failures++;
        $display("FAIL dev_rd got=%b exp=%b t=%0t", bus_in[5:4], e.dev, $time);
      end
      if (e.chk_ram) begin
        checks++;
        if (bus_in[3:0] !== e.ram) begin
          failures++;
          $display("FAIL ram_rd got=%h exp=%h t=%0t", bus_in[3:0], e.ram, $time);
        end
      end
    end
  end

  task automatic cycle(input logic [7:0] bo, input logic rst, input logic lv,
                       input logic [7:0] la, input logic [7:0] ld, input logic chk);
    exp_t       e;
    logic [7:0] b;
    logic [7:0] di;
    int         sp;
    int         k;
    di         = 8'($urandom);
    bus_out    = bo;
    reset      = rst;
    load_valid = lv;
    load_addr  = la;
    load_data  = ld;
    dev_in     = di;
    sp         = bo[7] ? 0 : int'(bo[6]);
    b          = m_mem[sp][m_addr];
    k          = m_addr % 4;
    e.chk_ram  = chk;
    e.ram      = m_lo ? b[3:0] : b[7:4];
    e.dev      = {di[2*k+1], di[2*k]};
    e.dout     = {m_dev[3], m_dev[2], m_dev[1], m_dev[0]};
    e.rdy      = rst;
    sb.push_back(e);
    @(posedge clk);
    if (rst) begin
      m_addr = 0;
      m_lo   = 0;
      for (int i = 0; i < 4; i++) m_dev[i] = 4'h0;
      if (lv) m_mem[la[7]][la[6:0]] = ld;
    end else if (bo[7]) begin
      m_addr = int'(bo[6:0]);
      m_lo   = 0;
    end else begin
      if (!bo[5]) begin
        if (m_lo) m_mem[bo[6]][m_addr][3:0] = bo[3:0];
        else      m_mem[bo[6]][m_addr][7:4] = bo[3:0];
      end
      if (!bo[4]) m_dev[m_addr % 4] = bo[3:0];
      m_lo = 1;
    end
    #1;
  endtask

  task automatic strobe(input logic [6:0] a);
    cycle({1'b1, a}, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic nib(input logic cs, input logic ram_we_n, input logic dev_we_n, input logic [3:0] d);
    cycle({1'b0, cs, ram_we_n, dev_we_n, d}, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic rst_cycle(input logic lv, input logic [7:0] la, input logic [7:0] ld, input logic chk);
    cycle(8'($urandom), 1'b1, lv, la, ld, chk);
  endtask

  initial begin
    logic [7:0] d;
    reset      = 1'b1;
    bus_out    = 8'h00;
    dev_in     = 8'h00;
    load_valid = 1'b0;
    load_addr  = 8'h00;
    load_data  = 8'h00;
    m_addr     = 0;
    m_lo       = 0;
    for (int i = 0; i < 4; i++) m_dev[i] = 4'h0;
    @(posedge clk);
    #1;

    // Preload every byte under reset; memory is unknown until this finishes.
    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom);
      if (i == 8'h85) d = 8'hA7;
      if (i == 8'h20) d = 8'hFF;
      rst_cycle(1'b1, 8'(i), d, 1'b0);
    end
    rst_cycle(1'b0, 8'h00, 8'h00, 1'b1);

    // Preloaded code byte read back nibble-serially.
    strobe(7'h05); nib(1'b1, 1'b1, 1'b1, 4'h0); nib(1'b1, 1'b1, 1'b1, 4'h0);

    // Bus write to data space, then re-read data and code at the same address.
    strobe(7'h12); nib(1'b0, 1'b0, 1'b1, 4'h3); nib(1'b0, 1'b0, 1'b1, 4'hC);
    strobe(7'h12); nib(1'b0, 1'b1, 1'b1, 4'h0); nib(1'b0, 1'b1, 1'b1, 4'h0);
    strobe(7'h12); nib(1'b1, 1'b1, 1'b1, 4'h0); nib(1'b1, 1'b1, 1'b1, 4'h0);

    // Device write on both nibble clocks; the low nibble persists.
    strobe(7'h02); nib(1'b0, 1'b1, 1'b0, 4'h5); nib(1'b0, 1'b1, 1'b0, 4'h9);
    nib(1'b0, 1'b1, 1'b1, 4'h0);

    // Device read through an address that aliases device 1.
    strobe(7'h41); nib(1'b0, 1'b1, 1'b1, 4'h0);

    // Reset after the high-nibble write; the byte keeps the new high nibble.
    strobe(7'h20); nib(1'b0, 1'b0, 1'b1, 4'h1);
    rst_cycle(1'b0, 8'h00, 8'h00, 1'b1);
    strobe(7'h20); nib(1'b0, 1'b1, 1'b1, 4'h0); nib(1'b0, 1'b1, 1'b1, 4'h0);

    // Load request outside reset is ignored.
    cycle(8'h30, 1'b0, 1'b1, 8'h85, 8'h00, 1'b1);
    strobe(7'h05); nib(1'b1, 1'b1, 1'b1, 4'h0); nib(1'b1, 1'b1, 1'b1, 4'h0);

    // Randomized CPU-like transactions with occasional resets and host loads.
    repeat (300) begin
      int n;
      if ($urandom_range(0, 19) == 0)
        rst_cycle(1'($urandom), 8'($urandom), 8'($urandom), 1'b1);
      if ($urandom_range(0, 1) == 0) strobe(7'($urandom_range(0, 15)));
      else                           strobe(7'($urandom));
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 9) == 0)
          cycle(8'h00 | 8'($urandom_range(0, 127)), 1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'b1);
        else
          nib(1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 4'($urandom));
      end
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
